// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter: round-robin share of one memory port between the
// fwrisc fetch (i*) and data (d*) ports, one transaction in flight at a time.
module fwrisc_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    // fetch port
    input  logic [ADDR_WIDTH-1:0]     iaddr,
    output logic [DATA_WIDTH-1:0]     idata,
    input  logic                      ivalid,
    output logic                      iready,
    // data port
    input  logic [ADDR_WIDTH-1:0]     daddr,
    input  logic [DATA_WIDTH-1:0]     dwdata,
    output logic [DATA_WIDTH-1:0]     drdata,
    input  logic [DATA_WIDTH/8-1:0]   dstrb,
    input  logic                      dwrite,
    input  logic                      dvalid,
    output logic                      dready,
    // memory port
    output logic [ADDR_WIDTH-1:0]     maddr,
    output logic [DATA_WIDTH-1:0]     mwdata,
    input  logic [DATA_WIDTH-1:0]     mrdata,
    output logic [DATA_WIDTH/8-1:0]   mstrb,
    output logic                      mwrite,
    output logic                      mvalid,
    input  logic                      mready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant_d;   // 1: data port won the most recent grant
    logic   i_wins;

    // Fetch wins when it is the only requester, or on a tie after a data grant
    assign i_wins = ivalid && (!dvalid || last_grant_d);

    // Grant FSM and registered memory request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            mvalid       <= 1'b0;
            maddr        <= '0;
            mwdata       <= '0;
            mstrb        <= '0;
            mwrite       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wins) begin
                        state        <= GNT_I;
                        last_grant_d <= 1'b0;
                        mvalid       <= 1'b1;
                        maddr        <= iaddr;
                        mwdata       <= '0;
                        mstrb        <= {STRB_WIDTH{1'b1}};
                        mwrite       <= 1'b0;
                    end else if (dvalid) begin
                        state        <= GNT_D;
                        last_grant_d <= 1'b1;
                        mvalid       <= 1'b1;
                        maddr        <= daddr;
                        mwdata       <= dwdata;
                        mstrb        <= dstrb;
                        mwrite       <= dwrite;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mready) begin
                        state  <= IDLE;
                        mvalid <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mvalid <= 1'b0;
                end
            endcase
        end
    end

    // Completion passes straight through from the memory to the owning port
    always_comb begin
        iready = (state == GNT_I) && mready;
        dready = (state == GNT_D) && mready;
        idata  = iready ? mrdata : '0;
        drdata = dready ? mrdata : '0;
    end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed bench for fwrisc_mem_arbiter: per-cycle vector table plus
// hand-written sequences for alternation, async reset and spurious mready.
module tb_fwrisc_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] idata;
    logic        ivalid = 1'b0;
    logic        iready;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [31:0] drdata;
    logic [3:0]  dstrb = '0;
    logic        dwrite = 1'b0;
    logic        dvalid = 1'b0;
    logic        dready;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata = '0;
    logic [3:0]  mstrb;
    logic        mwrite;
    logic        mvalid;
    logic        mready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fwrisc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clock  (clock),
        .reset_n(reset_n),
        .iaddr  (iaddr),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .dstrb  (dstrb),
        .dwrite (dwrite),
        .dvalid (dvalid),
        .dready (dready),
        .maddr  (maddr),
        .mwdata (mwdata),
        .mrdata (mrdata),
        .mstrb  (mstrb),
        .mwrite (mwrite),
        .mvalid (mvalid),
        .mready (mready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        dwr;
        logic        mr;
        logic [31:0] md;
        logic        e_mv;
        logic [31:0] e_ma;
        logic [31:0] e_mw;
        logic [3:0]  e_ms;
        logic        e_mwr;
        logic        e_ir;
        logic [31:0] e_id;
        logic        e_dr;
        logic [31:0] e_dd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic row(input logic rst,
                       input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] ds, input logic dwr,
                       input logic mr, input logic [31:0] md,
                       input logic e_mv, input logic [31:0] e_ma, input logic [31:0] e_mw,
                       input logic [3:0] e_ms, input logic e_mwr,
                       input logic e_ir, input logic [31:0] e_id,
                       input logic e_dr, input logic [31:0] e_dd);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw;
        v.ds = ds; v.dwr = dwr; v.mr = mr; v.md = md;
        v.e_mv = e_mv; v.e_ma = e_ma; v.e_mw = e_mw; v.e_ms = e_ms; v.e_mwr = e_mwr;
        v.e_ir = e_ir; v.e_id = e_id; v.e_dr = e_dr; v.e_dd = e_dd;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        ivalid = 1'b0; iaddr = '0; dvalid = 1'b0; daddr = '0;
        dwdata = '0; dstrb = '0; dwrite = 1'b0; mready = 1'b0; mrdata = '0;
    endtask

    // Assert reset on a falling edge, check reset state, release two cycles later
    task automatic do_reset(input int tag);
        @(negedge clock);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_mvalid", tag, 32'(mvalid), 32'h0);
        check("rst_maddr",  tag, maddr, 32'h0);
        check("rst_mwdata", tag, mwdata, 32'h0);
        check("rst_mstrb",  tag, 32'(mstrb), 32'h0);
        check("rst_mwrite", tag, 32'(mwrite), 32'h0);
        check("rst_ready",  tag, {30'h0, iready, dready}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset then single fetch, memory answers the cycle mvalid rises
        row(1, 1,32'h100, 0,0,0,4'h0,0, 0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);
        row(0, 1,32'h100, 0,0,0,4'h0,0, 1,32'h13,       1,32'h100,0,4'hF,0, 1,32'h13,0,0);
        row(0, 0,0,       0,0,0,4'h0,0, 0,32'hAAAAAAAA, 0,0,0,4'h0,0, 0,0,0,0);
        // Simultaneous requests after reset: fetch first, idle, then data
        row(1, 1,32'h200, 1,32'h8000,0,4'hF,0, 0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);
        row(0, 1,32'h200, 1,32'h8000,0,4'hF,0, 1,32'h11111111, 1,32'h200,0,4'hF,0, 1,32'h11111111,0,0);
        row(0, 0,0,       1,32'h8000,0,4'hF,0, 0,32'hAAAAAAAA, 0,0,0,4'h0,0, 0,0,0,0);
        row(0, 0,0,       1,32'h8000,0,4'hF,0, 1,32'h22222222, 1,32'h8000,0,4'hF,0, 0,0,1,32'h22222222);
        row(0, 0,0,       0,0,0,4'h0,0,        0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);
        // Store with three wait cycles while fetch waits as the loser
        row(1, 0,0,       1,32'h40,32'hDEADBEEF,4'h3,1, 0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);
        row(0, 1,32'h500, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,32'h55555555, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,0,0,0);
        row(0, 1,32'h500, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,32'h55555555, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,0,0,0);
        row(0, 1,32'h500, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,32'h55555555, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,0,0,0);
        row(0, 1,32'h500, 1,32'h40,32'hDEADBEEF,4'h3,1, 1,32'hCAFEF00D, 1,32'h40,32'hDEADBEEF,4'h3,1, 0,0,1,32'hCAFEF00D);
        row(0, 1,32'h500, 0,0,0,4'h0,0,                 0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);
        row(0, 1,32'h500, 0,0,0,4'h0,0,                 1,32'h33,       1,32'h500,0,4'hF,0, 1,32'h33,0,0);
        row(0, 0,0,       0,0,0,4'h0,0,                 0,32'h0,        0,0,0,4'h0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset(i);
            else @(negedge clock);
            ivalid = vecs[i].iv; iaddr = vecs[i].ia;
            dvalid = vecs[i].dv; daddr = vecs[i].da; dwdata = vecs[i].dw;
            dstrb = vecs[i].ds; dwrite = vecs[i].dwr;
            mready = vecs[i].mr; mrdata = vecs[i].md;
            #1;
            check("mvalid", i, 32'(mvalid), 32'(vecs[i].e_mv));
            check("iready", i, 32'(iready), 32'(vecs[i].e_ir));
            check("idata",  i, idata, vecs[i].e_id);
            check("dready", i, 32'(dready), 32'(vecs[i].e_dr));
            check("drdata", i, drdata, vecs[i].e_dd);
            if (vecs[i].e_mv) begin
                check("maddr",  i, maddr, vecs[i].e_ma);
                check("mstrb",  i, 32'(mstrb), 32'(vecs[i].e_ms));
                check("mwrite", i, 32'(mwrite), 32'(vecs[i].e_mwr));
                if (vecs[i].e_mwr) check("mwdata", i, mwdata, vecs[i].e_mw);
            end
        end

        // Both ports request continuously: grants alternate I,D,... one per two cycles
        begin
            int n_trans;
            logic exp_i;
            n_trans = 0;
            do_reset(100);
            ivalid = 1'b1; iaddr = 32'h300;
            dvalid = 1'b1; daddr = 32'h9000; dwrite = 1'b0; dstrb = 4'hF;
            for (int c = 0; c < 16; c++) begin
                if (c != 0) @(negedge clock);
                mready = c[0];
                mrdata = 32'h1000 + 32'(c);
                #1;
                if (!c[0]) begin
                    check("alt_mvalid_idle", c, 32'(mvalid), 32'h0);
                    check("alt_ready_idle",  c, {30'h0, iready, dready}, 32'h0);
                end else begin
                    exp_i = ((c / 2) % 2) == 0;
                    check("alt_mvalid", c, 32'(mvalid), 32'h1);
                    check("alt_iready", c, 32'(iready), 32'(exp_i));
                    check("alt_dready", c, 32'(dready), 32'(!exp_i));
                    check("alt_maddr",  c, maddr, exp_i ? 32'h300 : 32'h9000);
                    if (iready || dready) n_trans++;
                end
            end
            check("alt_count", 0, 32'(n_trans), 32'd8);
        end

        // Reset while the data port owns the bus aborts without a ready pulse
        do_reset(200);
        dvalid = 1'b1; daddr = 32'h60; dwrite = 1'b0; dstrb = 4'hF;
        @(negedge clock);
        #1;
        check("abort_mvalid_pre", 0, 32'(mvalid), 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_mvalid_async", 0, 32'(mvalid), 32'h0);
        dvalid = 1'b0;
        mready = 1'b1; mrdata = 32'h77;
        #1;
        check("abort_ready_in_rst", 0, {30'h0, iready, dready}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("abort_ready_post", 0, {30'h0, iready, dready}, 32'h0);
        check("abort_drdata_post", 0, drdata, 32'h0);

        // Spurious mready in IDLE with no requests, then a normal fetch still works
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            mready = 1'b1; mrdata = 32'h99;
            #1;
            check("spur_ready",  c, {30'h0, iready, dready}, 32'h0);
            check("spur_mvalid", c, 32'(mvalid), 32'h0);
        end
        @(negedge clock);
        mready = 1'b0; ivalid = 1'b1; iaddr = 32'h700;
        @(negedge clock);
        mready = 1'b1; mrdata = 32'h1234;
        #1;
        check("spur_fetch_iready", 0, 32'(iready), 32'h1);
        check("spur_fetch_maddr",  0, maddr, 32'h700);
        check("spur_fetch_idata",  0, idata, 32'h1234);
        @(negedge clock);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
